// File: rtl/spectrum_bank_if.sv
// Magnitude stream from the FFT into the spectrum bank controller.
// Carries valid/ready, bin magnitude and end-of-frame marker.
interface spectrum_bank_if #(
    parameter int MAG_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [MAG_W-1:0] s_mag;
    logic             s_last;

    modport master (output s_valid, s_mag, s_last, input s_ready);
    modport slave  (input s_valid, s_mag, s_last, output s_ready);
endinterface

// File: rtl/spectrum_bank_ctrl.sv
// Ping-pong bank controller for the spectrum magnitude RAM; swaps banks only at vblank start.
// Optional feature: define SPEC_ERR_CNT_EN to add the saturating err_cnt output.
module spectrum_bank_ctrl #(
    parameter int  NPOINT   = 1024,
    parameter int  MAG_W    = 16,
    parameter int  V_ACTIVE = 720,
    localparam int AW       = $clog2(NPOINT / 2)
) (
    input  logic              pix_clk,
    input  logic              rst,
    spectrum_bank_if.slave    s,
    input  logic [11:0]       y,
    input  logic [AW-1:0]     rd_addr,
    output logic [AW:0]       ram_addr_b,
    output logic              ram_we_a,
    output logic [AW:0]       ram_addr_a,
    output logic [MAG_W-1:0]  ram_din_a,
    output logic              front_bank,
    output logic              frame_pending,
    output logic              err_len
`ifdef SPEC_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam int BIN_COUNT = NPOINT / 2;

    typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;

    state_t        state_p0, state_nxt;
    logic [AW-1:0] wr_cnt_p0, wr_cnt_nxt;
    logic          blank_p0;
    logic          in_blank, vbs, accept, bin_end;
    logic          we_nxt, err_nxt, pend_set, swap;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ready is forced low while reset is held, not just after it.
    assign s.s_ready  = !rst && (state_p0 != HOLD);
    assign ram_addr_b = {front_bank, rd_addr};
    assign in_blank   = (y >= 12'(V_ACTIVE));
    assign vbs        = in_blank && !blank_p0;
    assign accept     = s.s_valid && s.s_ready;
    assign bin_end    = (wr_cnt_p0 == AW'(BIN_COUNT - 1));

    always_comb begin
        state_nxt  = state_p0;
        wr_cnt_nxt = wr_cnt_p0;
        we_nxt     = 1'b0;
        err_nxt    = 1'b0;
        pend_set   = 1'b0;
        swap       = 1'b0;
        case (state_p0)
            FILL: begin
                if (accept) begin
                    we_nxt = 1'b1;
                    if (s.s_last && bin_end) begin
                        state_nxt  = HOLD;
                        wr_cnt_nxt = '0;
                        pend_set   = 1'b1;
                    end else if (s.s_last) begin
                        err_nxt    = 1'b1;
                        wr_cnt_nxt = '0;
                    end else if (bin_end) begin
                        // Overlong frame: keep the full bank's worth, drop the tail.
                        err_nxt    = 1'b1;
                        wr_cnt_nxt = '0;
                        state_nxt  = DRAIN;
                    end else begin
                        wr_cnt_nxt = wr_cnt_p0 + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && s.s_last) state_nxt = FILL;
            end
            HOLD: begin
                if (vbs) begin
                    swap      = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // p0: control state, bank select and registered RAM write port
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_p0      <= FILL;
            wr_cnt_p0     <= '0;
            blank_p0      <= 1'b1;
            front_bank    <= 1'b0;
            frame_pending <= 1'b0;
            ram_we_a      <= 1'b0;
            ram_addr_a    <= '0;
            ram_din_a     <= '0;
            err_len       <= 1'b0;
        end else begin
            state_p0  <= state_nxt;
            wr_cnt_p0 <= wr_cnt_nxt;
            blank_p0  <= in_blank;
            if (swap) begin
                front_bank    <= ~front_bank;
                frame_pending <= 1'b0;
            end else if (pend_set) begin
                frame_pending <= 1'b1;
            end
            ram_we_a <= we_nxt;
            if (we_nxt) begin
                ram_addr_a <= {~front_bank, wr_cnt_p0};
                ram_din_a  <= s.s_mag;
            end
            err_len <= err_nxt;
        end
    end

`ifdef SPEC_ERR_CNT_EN
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst)          err_cnt <= 16'd0;
        else if (err_nxt) err_cnt <= sat_inc16(err_cnt);
    end
`endif

endmodule

// File: tb/tb_spectrum_bank_ctrl.sv
// Bench for spectrum_bank_ctrl: directed frame sequences, a vector table and a
// randomized run against a frame-level reference model.
module tb_spectrum_bank_ctrl;

    logic        pix_clk = 1'b0;
    logic        rst;
    logic [11:0] y;
    logic [8:0]  rd_addr;
    logic [9:0]  ram_addr_b;
    logic        ram_we_a;
    logic [9:0]  ram_addr_a;
    logic [15:0] ram_din_a;
    logic        front_bank;
    logic        frame_pending;
    logic        err_len;
`ifdef SPEC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int   total = 0;
    int   bad   = 0;
    int   seed  = 0;
    logic exp_front;

    always #5 pix_clk = ~pix_clk;

    spectrum_bank_if #(.MAG_W(16)) sif ();

    spectrum_bank_ctrl #(.NPOINT(1024), .MAG_W(16), .V_ACTIVE(720)) dut (
        .pix_clk      (pix_clk),
        .rst          (rst),
        .s            (sif),
        .y            (y),
        .rd_addr      (rd_addr),
        .ram_addr_b   (ram_addr_b),
        .ram_we_a     (ram_we_a),
        .ram_addr_a   (ram_addr_a),
        .ram_din_a    (ram_din_a),
        .front_bank   (front_bank),
        .frame_pending(frame_pending),
        .err_len      (err_len)
`ifdef SPEC_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic        l;
        logic [15:0] m;
        logic [11:0] yy;
        logic [8:0]  ra;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [15:0] e_din;
        logic        e_front;
        logic        e_pend;
        logic        e_ready;
        logic        e_err;
        logic [9:0]  e_addr_b;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mag_of(input int i);
        return 16'(i * 37 + seed);
    endfunction

    task automatic beat(input logic v, input logic l, input logic [15:0] m);
        sif.s_valid = v;
        sif.s_last  = l;
        sif.s_mag   = m;
        @(posedge pix_clk);
        #1;
    endtask

    task automatic fill_beats(input int from, input int to, input logic last_at_end);
        for (int i = from; i <= to; i++) begin
            beat(1'b1, last_at_end && (i == to), mag_of(i));
            chk("wr_en", 32'(ram_we_a), 32'(1));
            chk("wr_addr", 32'(ram_addr_a), 32'({~exp_front, 9'(i)}));
            chk("wr_data", 32'(ram_din_a), 32'(mag_of(i)));
            if (i != to) chk("err_quiet", 32'(err_len), 32'(0));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_front"}, 32'(front_bank), 32'(0));
        chk({tag, "_pend"}, 32'(frame_pending), 32'(0));
        chk({tag, "_we"}, 32'(ram_we_a), 32'(0));
        chk({tag, "_addr"}, 32'(ram_addr_a), 32'(0));
        chk({tag, "_din"}, 32'(ram_din_a), 32'(0));
        chk({tag, "_err"}, 32'(err_len), 32'(0));
        chk({tag, "_ready"}, 32'(sif.s_ready), 32'(0));
`ifdef SPEC_ERR_CNT_EN
        chk({tag, "_errcnt"}, 32'(err_cnt), 32'(0));
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reference-model state for the randomized run
        logic        m_front, m_pending, m_discard, m_blank;
        int          m_bin, m_errs;
        int          beat_idx, frame_len, ycur;
        logic        v, l, acc, e_we, e_err, vbs;
        logic [15:0] m;
        logic [9:0]  e_addr;

        rst = 1'b1;
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_mag   = '0;
        y = '0;
        rd_addr = '0;
        exp_front = 1'b0;
        #2;
        chk_reset_vals("reset_async");
        repeat (3) @(posedge pix_clk);
        #1;
        chk_reset_vals("reset_held");
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(sif.s_ready), 32'(1));

        // Full frame into bank 1, backpressure, swap at vblank
        seed = 7;
        fill_beats(0, 511, 1'b1);
        chk("f1_err", 32'(err_len), 32'(0));
        chk("f1_pend", 32'(frame_pending), 32'(1));
        chk("f1_ready_low", 32'(sif.s_ready), 32'(0));
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, 1'b0, 16'hDEAD);
            chk("hold_no_write", 32'(ram_we_a), 32'(0));
            chk("hold_ready", 32'(sif.s_ready), 32'(0));
            chk("hold_front", 32'(front_bank), 32'(0));
        end
        y = 12'd720;
        rd_addr = 9'd5;
        beat(1'b0, 1'b0, 16'h0);
        exp_front = 1'b1;
        chk("swap1_front", 32'(front_bank), 32'(1));
        chk("swap1_pend", 32'(frame_pending), 32'(0));
        chk("swap1_ready", 32'(sif.s_ready), 32'(1));
        chk("swap1_addr_b", 32'(ram_addr_b), 32'(10'h205));
        y = 12'd0;
        beat(1'b0, 1'b0, 16'h0);

        // Second frame into bank 0 with a vblank in the middle
        seed = 100;
        fill_beats(0, 199, 1'b0);
        y = 12'd720;
        beat(1'b0, 1'b0, 16'h0);
        chk("midframe_no_swap", 32'(front_bank), 32'(1));
        y = 12'd0;
        beat(1'b0, 1'b0, 16'h0);
        fill_beats(200, 511, 1'b1);
        chk("f2_pend", 32'(frame_pending), 32'(1));
        y = 12'd720;
        beat(1'b0, 1'b0, 16'h0);
        exp_front = 1'b0;
        chk("swap2_front", 32'(front_bank), 32'(0));
        y = 12'd0;
        beat(1'b0, 1'b0, 16'h0);

        // Short frame ending on bin 99
        seed = 3;
        fill_beats(0, 99, 1'b1);
        chk("short_err", 32'(err_len), 32'(1));
        chk("short_pend", 32'(frame_pending), 32'(0));
        beat(1'b0, 1'b0, 16'h0);
        chk("short_err_one_cycle", 32'(err_len), 32'(0));
        fill_beats(0, 511, 1'b1);
        chk("after_short_pend", 32'(frame_pending), 32'(1));
        y = 12'd720;
        beat(1'b0, 1'b0, 16'h0);
        exp_front = 1'b1;
        chk("swap3_front", 32'(front_bank), 32'(1));
        y = 12'd0;
        beat(1'b0, 1'b0, 16'h0);

        // Long frame of 600 beats
        seed = 55;
        fill_beats(0, 511, 1'b0);
        chk("long_err", 32'(err_len), 32'(1));
        for (int i = 512; i < 600; i++) begin
            beat(1'b1, i == 599, mag_of(i));
            chk("drain_no_write", 32'(ram_we_a), 32'(0));
            chk("drain_err", 32'(err_len), 32'(0));
            chk("drain_ready", 32'(sif.s_ready), 32'(1));
        end
        chk("long_pend", 32'(frame_pending), 32'(0));
        y = 12'd720;
        beat(1'b0, 1'b0, 16'h0);
        chk("long_no_swap", 32'(front_bank), 32'(1));
        y = 12'd0;
        beat(1'b0, 1'b0, 16'h0);
        fill_beats(0, 0, 1'b0);

        // Completion in the same cycle as vblank start
        fill_beats(1, 510, 1'b0);
        y = 12'd720;
        beat(1'b1, 1'b1, mag_of(511));
        chk("same_wr_addr", 32'(ram_addr_a), 32'({~exp_front, 9'd511}));
        chk("same_pend", 32'(frame_pending), 32'(1));
        chk("same_no_swap", 32'(front_bank), 32'(1));
        for (int k = 0; k < 3; k++) begin
            beat(1'b0, 1'b0, 16'h0);
            chk("same_blank_hold", 32'(front_bank), 32'(1));
            chk("same_blank_ready", 32'(sif.s_ready), 32'(0));
        end
        y = 12'd0;
        beat(1'b0, 1'b0, 16'h0);
        y = 12'd720;
        beat(1'b0, 1'b0, 16'h0);
        exp_front = 1'b0;
        chk("same_next_swap", 32'(front_bank), 32'(0));
        y = 12'd0;
        beat(1'b0, 1'b0, 16'h0);

        // Reset mid-frame with a frame pending
        seed = 9;
        fill_beats(0, 511, 1'b1);
        chk("rst_pre_pend", 32'(frame_pending), 32'(1));
`ifdef SPEC_ERR_CNT_EN
        chk("errcnt_two", 32'(err_cnt), 32'(2));
`endif
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("reset_mid");
        chk("reset_addr_b", 32'(ram_addr_b), 32'(10'h005));
        @(posedge pix_clk);
        #1;
        rst = 1'b0;
        exp_front = 1'b0;
        for (int n = 0; n < 3; n++) begin
            fill_beats(0, n, 1'b1);
            chk("bad_frame_err", 32'(err_len), 32'(1));
        end
`ifdef SPEC_ERR_CNT_EN
        chk("errcnt_three", 32'(err_cnt), 32'(3));
`endif
        beat(1'b0, 1'b0, 16'h0);

        // Vector table: starts in FILL at bin 0, front bank 0, y below blank
        tbl[0] = '{1'b1, 1'b0, 16'h1111, 12'd0,   9'd3,   1'b1, 10'h200, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 10'h003};
        tbl[1] = '{1'b0, 1'b0, 16'h2222, 12'd0,   9'd4,   1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 10'h004};
        tbl[2] = '{1'b1, 1'b0, 16'h3333, 12'd0,   9'd5,   1'b1, 10'h201, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b0, 10'h005};
        tbl[3] = '{1'b1, 1'b1, 16'h4444, 12'd0,   9'd6,   1'b1, 10'h202, 16'h4444, 1'b0, 1'b0, 1'b1, 1'b1, 10'h006};
        tbl[4] = '{1'b1, 1'b0, 16'h5555, 12'd720, 9'd7,   1'b1, 10'h200, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 10'h007};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 12'd0,   9'h1FF, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 10'h1FF};
        tbl[6] = '{1'b1, 1'b0, 16'h6666, 12'd0,   9'd0,   1'b1, 10'h201, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000};
        for (int t = 0; t < 7; t++) begin
            y = tbl[t].yy;
            rd_addr = tbl[t].ra;
            beat(tbl[t].v, tbl[t].l, tbl[t].m);
            chk($sformatf("vec%0d_we", t), 32'(ram_we_a), 32'(tbl[t].e_we));
            if (tbl[t].e_we) begin
                chk($sformatf("vec%0d_addr", t), 32'(ram_addr_a), 32'(tbl[t].e_addr));
                chk($sformatf("vec%0d_din", t), 32'(ram_din_a), 32'(tbl[t].e_din));
            end
            chk($sformatf("vec%0d_front", t), 32'(front_bank), 32'(tbl[t].e_front));
            chk($sformatf("vec%0d_pend", t), 32'(frame_pending), 32'(tbl[t].e_pend));
            chk($sformatf("vec%0d_ready", t), 32'(sif.s_ready), 32'(tbl[t].e_ready));
            chk($sformatf("vec%0d_err", t), 32'(err_len), 32'(tbl[t].e_err));
            chk($sformatf("vec%0d_addr_b", t), 32'(ram_addr_b), 32'(tbl[t].e_addr_b));
        end

        // Randomized run against the frame-level model
        rst = 1'b1;
        y = 12'd0;
        sif.s_valid = 1'b0;
        @(posedge pix_clk);
        #1;
        rst = 1'b0;
        m_front = 1'b0; m_pending = 1'b0; m_discard = 1'b0; m_blank = 1'b1;
        m_bin = 0; m_errs = 0; beat_idx = 0; frame_len = 512; ycur = 0;
        for (int c = 0; c < 15000; c++) begin
            ycur = ycur + int'($urandom_range(1, 4));
            if (ycur >= 750) ycur = 0;
            v = ($urandom_range(0, 3) != 0);
            l = (beat_idx == frame_len - 1);
            m = 16'($urandom);
            y = 12'(ycur);
            rd_addr = 9'($urandom);

            acc    = v && !m_pending;
            e_we   = acc && !m_discard;
            e_addr = {~m_front, 9'(m_bin)};
            e_err  = e_we && (l ? (m_bin != 511) : (m_bin == 511));
            vbs    = (ycur >= 720) && !m_blank;
            if (m_pending && vbs) begin
                m_front = ~m_front;
                m_pending = 1'b0;
            end else if (acc) begin
                if (m_discard) begin
                    if (l) m_discard = 1'b0;
                end else if (l) begin
                    if (m_bin == 511) m_pending = 1'b1;
                    m_bin = 0;
                end else if (m_bin == 511) begin
                    m_bin = 0;
                    m_discard = 1'b1;
                end else begin
                    m_bin++;
                end
            end
            m_blank = (ycur >= 720);
            if (e_err && m_errs != 65535) m_errs++;
            if (acc) begin
                if (l) begin
                    beat_idx = 0;
                    case ($urandom_range(0, 9))
                        7:       frame_len = int'($urandom_range(1, 511));
                        8, 9:    frame_len = int'($urandom_range(513, 700));
                        default: frame_len = 512;
                    endcase
                end else begin
                    beat_idx++;
                end
            end

            beat(v, l, m);
            chk("rnd_we", 32'(ram_we_a), 32'(e_we));
            if (e_we) begin
                chk("rnd_addr", 32'(ram_addr_a), 32'(e_addr));
                chk("rnd_din", 32'(ram_din_a), 32'(m));
            end
            chk("rnd_err", 32'(err_len), 32'(e_err));
            chk("rnd_front", 32'(front_bank), 32'(m_front));
            chk("rnd_pend", 32'(frame_pending), 32'(m_pending));
            chk("rnd_ready", 32'(sif.s_ready), 32'(!m_pending));
            chk("rnd_addr_b", 32'(ram_addr_b), 32'({m_front, rd_addr}));
`ifdef SPEC_ERR_CNT_EN
            chk("rnd_errcnt", 32'(err_cnt), 32'(m_errs));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
